pcie_crdt_up_tracker: RTL
=========================

# pcie_crdt_up_tracker

Credit flow-control tracker for the UP (host-bound, CC+RQ) direction of an R-Tile PCIe endpoint. It sits between the adapter's UP packet path and the tile's CRDT_UP interface. It accumulates the incremental credit updates the tile reports, then grants or blocks outgoing TLPs per MFB region so that header and data credits are never over-committed. It is the parametrised successor of the fixed credit pass-through: it supports any region count, configurable counter width, infinite-credit detection and modular (wrap-safe) accounting.

## Interface
- REGIONS, 4, TLP slots (MFB regions) evaluated per cycle
- CNT_W, 16, width of credit limit/consumed counters (modular)
- HDR_UPD_W, 2, width of header-credit update counts
- DATA_UPD_W, 4, width of data-credit update counts
- LEN_W, 11, width of payload length in DWORDs (0..1024)

Ports:
- CLK  in  1  clock
- RST_N  in  1  asynchronous reset, active low
- CRDT_INIT_DONE  in  1  tile finished advertising initial credits
- CRDT_UPDATE  in  6  update valid per type: [0]PH [1]NPH [2]CPLH [3]PD [4]NPD [5]CPLD
- CRDT_CNT_PH / CRDT_CNT_NPH / CRDT_CNT_CPLH  in  HDR_UPD_W  header credits added
- CRDT_CNT_PD / CRDT_CNT_NPD / CRDT_CNT_CPLD  in  DATA_UPD_W  data credits added
- TX_VLD  in  REGIONS  TLP request present in region r
- TX_TYPE  in  REGIONS*2  0=P, 1=NP, 2=CPL, 3=reserved (never granted)
- TX_LEN_DW  in  REGIONS*LEN_W  payload DWORDs (0 for reads/no-data)
- TX_GRANT  out  REGIONS  request accepted; credits consumed at this edge
- CRDT_READY  out  1  tracker in RUN state
- CRDT_ERR  out  1  sticky: available credits exceeded 2^(CNT_W-1)

## Operation
- Per type t (6 types): registers LIMIT_t, CONS_t (CNT_W, mod 2^CNT_W), flag INF_t. AVAIL_t = (LIMIT_t − CONS_t) mod 2^CNT_W.
- FSM:
  - INIT (after reset): updates add to LIMIT; TX_GRANT=0.
  - INIT → RUN on CRDT_INIT_DONE=1. At the transition, INF_t is set for every t whose LIMIT_t is 0 (updates in that same cycle included).
  - RUN → INIT when CRDT_INIT_DONE falls. All LIMIT, CONS, INF and CRDT_ERR are cleared.
- Updates accepted in both states: LIMIT_t += CRDT_CNT_t when CRDT_UPDATE[t]=1. The count is zero-extended.
- Demand per region: one header credit of class TX_TYPE; data credits = ceil(TX_LEN_DW/4) of the same class.
- Grant (combinational, RUN only), evaluated region 0 upward, in order:
  - TX_GRANT[r] = TX_VLD[r] & type≠3 & all lower valid regions granted & cumulative header and data demand of regions 0..r per class ≤ AVAIL (or INF).
  - A blocked region blocks all higher regions. No bypass, so TLP ordering is preserved.
- Consumption: at the edge, CONS_t += sum of granted demand for t. Skipped when INF_t is set.
- Simultaneous update + consumption on one type: both applied at the same edge. An update is not usable for grants until the next cycle.
- CRDT_ERR sets when the post-edge AVAIL_t of a non-INF type exceeds 2^(CNT_W-1). Cleared only by reset or by the INIT_DONE fall.
- Requester holds TX_* stable until granted; the tracker stores no request state.

## Timing
- Reset (RST_N=0, async): state INIT, all counters 0, TX_GRANT=0, CRDT_READY=0, CRDT_ERR=0.
- CRDT_READY rises 1 cycle after CRDT_INIT_DONE is first sampled high, and falls 1 cycle after it is sampled low.
- TX_GRANT has 0-cycle latency from TX_* and registered AVAIL. The credit effect is visible the next cycle.
- Update-to-availability latency: 1 cycle.
- Reset mid-traffic: grants drop immediately (async) and all credit state is lost.

## Test plan
- Init: with INIT_DONE=0, PH updates 3,3,2, then INIT_DONE=1 → CRDT_READY=1 next cycle; AVAIL_PH=8; INF_PH=0; TX_GRANT stays 0 throughout INIT.
- Header exhaustion: PH=2, PD infinite, 4 regions posted with len 0 → TX_GRANT=0011. Next cycle, regions re-presented → 0000. A PH update of 1 → the following cycle grants 0001.
- Data rounding/ordering: PD=3, PH=8. Regions 0..2 posted with len 9,1,0 → grant 001 (9 DW needs 3; region 1 needs 1 more, blocked; region 2 blocked by order).
- Mixed types: NPH=1, CPLH=1, CPLD infinite; regions = NP len0, CPL len 256, NP len0 → grant 011; AVAIL_NPH=0, AVAIL_CPLH=0 next cycle.
- Wrap-around: CNT_W=8, repeated PD updates of 15 with continuous 16-DW posted consumption over 300+ credits → grants never exceed AVAIL; CRDT_ERR stays 0.
- Re-init/reset: INIT_DONE dropped in RUN → CRDT_READY=0 next cycle and counters cleared. RST_N pulse with TX_VLD=1111 → TX_GRANT=0 immediately.

Source files
------------

// File: rtl/pcie_crdt_up_tracker.sv
// Credit tracker for the host-bound (posted/non-posted/completion) TLP path: accumulates
// tile credit updates and grants in-order MFB regions without over-committing credits.
module pcie_crdt_up_tracker #(
  parameter int REGIONS    = 4,
  parameter int CNT_W      = 16,
  parameter int HDR_UPD_W  = 2,
  parameter int DATA_UPD_W = 4,
  parameter int LEN_W      = 11
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     CRDT_INIT_DONE,
  input  logic [5:0]               CRDT_UPDATE,
  input  logic [HDR_UPD_W-1:0]     CRDT_CNT_PH,
  input  logic [HDR_UPD_W-1:0]     CRDT_CNT_NPH,
  input  logic [HDR_UPD_W-1:0]     CRDT_CNT_CPLH,
  input  logic [DATA_UPD_W-1:0]    CRDT_CNT_PD,
  input  logic [DATA_UPD_W-1:0]    CRDT_CNT_NPD,
  input  logic [DATA_UPD_W-1:0]    CRDT_CNT_CPLD,
  input  logic [REGIONS-1:0]       TX_VLD,
  input  logic [REGIONS*2-1:0]     TX_TYPE,
  input  logic [REGIONS*LEN_W-1:0] TX_LEN_DW,
  output logic [REGIONS-1:0]       TX_GRANT,
  output logic                     CRDT_READY,
  output logic                     CRDT_ERR
);
  // Type index t: 0..2 are PH/NPH/CPLH headers, 3..5 the matching data classes.
  localparam int NT    = 6;
  localparam int SUM_W = ((CNT_W > LEN_W) ? CNT_W : LEN_W) + $clog2(REGIONS + 1) + 1;
  localparam logic [CNT_W-1:0] HALF = {1'b1, {(CNT_W-1){1'b0}}};

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] limit_reg [NT];
  logic [CNT_W-1:0] cons_reg  [NT];
  logic [NT-1:0]    inf_reg;
  logic             err_reg;

  logic [CNT_W-1:0] upd_cnt    [NT];
  logic [CNT_W-1:0] avail      [NT];
  logic [CNT_W-1:0] limit_next [NT];
  logic [CNT_W-1:0] cons_next  [NT];
  logic [SUM_W-1:0] dem_sum    [NT];
  logic [NT-1:0]    inf_next;
  logic [NT-1:0]    over;

  logic [REGIONS-1:0] grant;
  logic               blocked;
  logic [1:0]         cls;
  logic [2:0]         hi;
  logic [2:0]         di;
  logic [SUM_W-1:0]   dcred;
  logic [SUM_W-1:0]   h_need;
  logic [SUM_W-1:0]   d_need;

  assign upd_cnt[0] = CNT_W'(CRDT_CNT_PH);
  assign upd_cnt[1] = CNT_W'(CRDT_CNT_NPH);
  assign upd_cnt[2] = CNT_W'(CRDT_CNT_CPLH);
  assign upd_cnt[3] = CNT_W'(CRDT_CNT_PD);
  assign upd_cnt[4] = CNT_W'(CRDT_CNT_NPD);
  assign upd_cnt[5] = CNT_W'(CRDT_CNT_CPLD);

  genvar gi;
  generate
    for (gi = 0; gi < NT; gi++) begin : g_type
      assign avail[gi]      = limit_reg[gi] - cons_reg[gi];
      assign limit_next[gi] = limit_reg[gi] + (CRDT_UPDATE[gi] ? upd_cnt[gi] : '0);
      assign cons_next[gi]  = inf_reg[gi] ? cons_reg[gi]
                                          : cons_reg[gi] + dem_sum[gi][CNT_W-1:0];
      // A class never advertised before INIT_DONE is treated as infinite.
      assign inf_next[gi]   = (state_reg == ST_INIT && CRDT_INIT_DONE)
                              ? (limit_next[gi] == '0) : inf_reg[gi];
      assign over[gi]       = !inf_next[gi] && ((limit_next[gi] - cons_next[gi]) > HALF);
    end
  endgenerate

  // In-order grant chain: the first blocked valid region stops all higher ones.
  always_comb begin
    blocked = (state_reg != ST_RUN);
    grant   = '0;
    cls     = '0;
    hi      = '0;
    di      = '0;
    dcred   = '0;
    h_need  = '0;
    d_need  = '0;
    for (int t = 0; t < NT; t++) dem_sum[t] = '0;
    for (int r = 0; r < REGIONS; r++) begin
      cls   = TX_TYPE[2*r +: 2];
      hi    = {1'b0, cls};
      di    = hi + 3'd3;
      dcred = (SUM_W'(TX_LEN_DW[r*LEN_W +: LEN_W]) + SUM_W'(3)) >> 2;
      if (TX_VLD[r]) begin
        if (blocked || cls == 2'd3) begin
          blocked = 1'b1;
        end else begin
          h_need = dem_sum[hi] + SUM_W'(1);
          d_need = dem_sum[di] + dcred;
          if ((inf_reg[hi] || h_need <= SUM_W'(avail[hi])) &&
              (inf_reg[di] || d_need <= SUM_W'(avail[di]))) begin
            grant[r]    = 1'b1;
            dem_sum[hi] = h_need;
            dem_sum[di] = d_need;
          end else begin
            blocked = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= ST_INIT;
      inf_reg   <= '0;
      err_reg   <= 1'b0;
      for (int t = 0; t < NT; t++) begin
        limit_reg[t] <= '0;
        cons_reg[t]  <= '0;
      end
    end else if (state_reg == ST_RUN && !CRDT_INIT_DONE) begin
      state_reg <= ST_INIT;
      inf_reg   <= '0;
      err_reg   <= 1'b0;
      for (int t = 0; t < NT; t++) begin
        limit_reg[t] <= '0;
        cons_reg[t]  <= '0;
      end
    end else begin
      if (state_reg == ST_INIT && CRDT_INIT_DONE) state_reg <= ST_RUN;
      inf_reg <= inf_next;
      if (|over) err_reg <= 1'b1;
      for (int t = 0; t < NT; t++) begin
        limit_reg[t] <= limit_next[t];
        cons_reg[t]  <= cons_next[t];
      end
    end
  end

  assign TX_GRANT   = grant;
  assign CRDT_READY = (state_reg == ST_RUN);
  assign CRDT_ERR   = err_reg;

endmodule
